program_memory: RTL and testbench

- Responder side of the processor's instruction-fetch interface: takes `pc` from the Microprocessor and returns `instruction` combinationally in the same cycle.
- Before execution, it accepts a program byte-stream over a valid/ready load port and stores it in an internal RAM.
- It holds the processor in reset until the load completes, so one bitstream can run different programs.

---
 rtl/program_memory_pkg.sv | 15 +
 rtl/program_memory_instr_ram.sv | 25 ++
 rtl/program_memory.sv | 136 +++++++++++++
 tb/tb_program_memory.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared types and constants for the instruction-fetch program memory.
// Holds the state encoding, the default fill byte and the processor fetch width.
package program_memory_pkg;

    localparam int FETCH_W = 8;
    localparam logic [FETCH_W-1:0] DEFAULT_FILL = 8'h00;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } pm_state_t;

endpackage

// File: rtl/program_memory_instr_ram.sv
// DEPTH x 8 instruction RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner rewrites every word before use.
module program_memory_instr_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_memory.sv
// Program memory for the processor's instruction fetch: clears itself, accepts a program
// byte stream, then releases the processor from reset and serves combinational fetches.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int          DEPTH = 32,
    parameter logic [7:0]  FILL  = DEFAULT_FILL
) (
    input  logic       origclk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       cpu_reset,
    output logic       running,
    output logic [7:0] prog_len,
    output logic       overflow_err,
    output logic [1:0] state_dbg
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    pm_state_t     state;
    pm_state_t     next_state;
    logic [AW-1:0] clr_ptr;
    logic [8:0]    wr_ptr;
    logic          accept;
    logic          has_room;
    logic          pc_in_range;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    // Load handshake: a byte transfers on a rising edge where load_valid && load_ready;
    // load_ready is high only in LOAD, and the loader may hold or change data freely otherwise.
    assign accept      = load_valid && load_ready;
    assign has_room    = wr_ptr < DEPTH_W;
    assign pc_in_range = {1'b0, pc} < DEPTH_W;

    assign load_ready  = (state == ST_LOAD);
    assign running     = (state == ST_RUN);
    assign cpu_reset   = (state != ST_RUN);
    assign state_dbg   = state;
    assign instruction = (running && pc_in_range) ? ram_rdata : FILL;

    always_comb begin
        next_state = state;
        ram_we     = 1'b0;
        ram_waddr  = clr_ptr;
        ram_wdata  = FILL;
        case (state)
            ST_CLEAR: begin
                ram_we = 1'b1;
                if (clr_ptr == LAST_IDX) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && has_room) begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_ptr[AW-1:0];
                    ram_wdata = load_data;
                end
                if (accept && load_last) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: next_state = ST_RUN;
            ST_RUN: begin
                if (load_start) begin
                    next_state = ST_CLEAR;
                end
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    always_ff @(posedge origclk or posedge reset) begin
        if (reset) begin
            state        <= ST_CLEAR;
            clr_ptr      <= '0;
            wr_ptr       <= '0;
            prog_len     <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    wr_ptr  <= '0;
                end
                ST_LOAD: begin
                    if (accept) begin
                        // Once full, further bytes are dropped and the pointer saturates.
                        if (has_room) begin
                            wr_ptr <= wr_ptr + 9'd1;
                        end else begin
                            overflow_err <= 1'b1;
                        end
                        if (load_last) begin
                            prog_len <= has_room ? 8'(wr_ptr + 9'd1) : wr_ptr[7:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start) begin
                        clr_ptr      <= '0;
                        wr_ptr       <= '0;
                        overflow_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    program_memory_instr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (origclk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (pc[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: fetch-vector table plus hand-written load,
// overflow, reload and mid-load reset sequences.
module tb_program_memory;
  import program_memory_pkg::*;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] exp;
  } vec_t;

  logic       origclk;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] pc;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic       running;
  logic [7:0] prog_len;
  logic       overflow_err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[8];

  program_memory dut (
    .origclk      (origclk),
    .reset        (reset),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .pc           (pc),
    .instruction  (instruction),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .prog_len     (prog_len),
    .overflow_err (overflow_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial begin
    origclk = 1'b0;
    forever #5 origclk = ~origclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge origclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic idle(input logic last);
    load_valid = 1'b0;
    load_last  = last;
    tick();
    load_last  = 1'b0;
  endtask

  task automatic wait_ready(output int n, output logic held);
    n = 0;
    held = 1'b1;
    while (!load_ready && n < 200) begin
      if (cpu_reset !== 1'b1) held = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [7:0] a, input logic [7:0] e);
    pc = a;
    #1;
    chk(name, {24'd0, instruction}, {24'd0, e});
  endtask

  task automatic drain_q(input string name);
    int a;
    a = 0;
    while (exp_q.size() > 0) begin
      fetch(name, 8'(a), exp_q.pop_front());
      a++;
    end
  endtask

  initial begin
    int n;
    logic held;

    vecs[0] = '{pc: 8'd0,   exp: 8'h44};
    vecs[1] = '{pc: 8'd1,   exp: 8'h49};
    vecs[2] = '{pc: 8'd2,   exp: 8'h19};
    vecs[3] = '{pc: 8'd3,   exp: 8'h84};
    vecs[4] = '{pc: 8'd4,   exp: 8'h00};
    vecs[5] = '{pc: 8'd31,  exp: 8'h00};
    vecs[6] = '{pc: 8'd32,  exp: 8'h00};
    vecs[7] = '{pc: 8'd200, exp: 8'h00};

    reset      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    pc         = 8'd0;
    #3;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_prog_len", {24'd0, prog_len}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_err}, 32'd0);
    chk("rst_instr", {24'd0, instruction}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'(ST_CLEAR));

    tick();
    reset = 1'b0;
    wait_ready(n, held);
    chk("clear_cycles", 32'(n), 32'd32);
    chk("clear_cpu_reset_held", {31'd0, held}, 32'd1);

    // basic 4-byte program
    send_byte(8'h44, 1'b0);
    send_byte(8'h49, 1'b0);
    send_byte(8'h19, 1'b0);
    send_byte(8'h84, 1'b1);
    chk("release_state", {30'd0, state_dbg}, 32'(ST_RELEASE));
    chk("release_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("release_ready", {31'd0, load_ready}, 32'd0);
    tick();
    chk("run_running", {31'd0, running}, 32'd1);
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("run_prog_len", {24'd0, prog_len}, 32'd4);
    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp);
    end

    // reload with gapped beats and a stray load_last on an idle cycle
    pulse_start();
    pc = 8'd0;
    #1;
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reload_instr", {24'd0, instruction}, 32'd0);
    chk("reload_prog_len_hold", {24'd0, prog_len}, 32'd4);
    wait_ready(n, held);
    chk("reload_clear_cycles", 32'(n), 32'd32);
    send_byte(8'hA0, 1'b0);
    idle(1'b0);
    send_byte(8'hA1, 1'b0);
    idle(1'b1);
    chk("idle_last_state", {30'd0, state_dbg}, 32'(ST_LOAD));
    chk("idle_last_ready", {31'd0, load_ready}, 32'd1);
    send_byte(8'hA2, 1'b0);
    idle(1'b0);
    send_byte(8'hA3, 1'b1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    tick();
    chk("gap_running", {31'd0, running}, 32'd1);
    chk("gap_prog_len", {24'd0, prog_len}, 32'd4);
    drain_q("gap_fetch");

    // overflow: 34 bytes into a 32-byte memory
    pulse_start();
    wait_ready(n, held);
    chk("ovf_clear_cycles", 32'(n), 32'd32);
    for (int i = 0; i < 34; i++) begin
      logic [7:0] b;
      b = 8'(i) ^ 8'h5A;
      if (i < 32) exp_q.push_back(b);
      send_byte(b, (i == 33));
      if (i == 31) chk("ovf_not_yet", {31'd0, overflow_err}, 32'd0);
      if (i == 32) chk("ovf_set", {31'd0, overflow_err}, 32'd1);
    end
    tick();
    chk("ovf_running", {31'd0, running}, 32'd1);
    chk("ovf_prog_len", {24'd0, prog_len}, 32'd32);
    chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    drain_q("ovf_fetch");
    fetch("ovf_pc32", 8'd32, 8'h00);

    // load_start together with load_valid in RUN: the byte must be ignored
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hEE;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    pc = 8'd0;
    #1;
    chk("restart_state", {30'd0, state_dbg}, 32'(ST_CLEAR));
    chk("restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("restart_ovf_clr", {31'd0, overflow_err}, 32'd0);
    chk("restart_instr", {24'd0, instruction}, 32'd0);
    wait_ready(n, held);
    chk("c3_clear_cycles", 32'(n), 32'd32);
    send_byte(8'hC3, 1'b1);
    tick();
    chk("c3_prog_len", {24'd0, prog_len}, 32'd1);
    fetch("c3_pc0", 8'd0, 8'hC3);
    fetch("c3_pc1", 8'd1, 8'h00);
    fetch("c3_pc31", 8'd31, 8'h00);

    // reset in the middle of a load
    pulse_start();
    wait_ready(n, held);
    chk("mid_clear_cycles", 32'(n), 32'd32);
    pulse_start();
    chk("start_in_load_ignored", {30'd0, state_dbg}, 32'(ST_LOAD));
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("mid_rst_state", {30'd0, state_dbg}, 32'(ST_CLEAR));
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd0);
    chk("mid_rst_prog_len", {24'd0, prog_len}, 32'd0);
    tick();
    reset = 1'b0;
    wait_ready(n, held);
    chk("mid_rst_clear_cycles", 32'(n), 32'd32);
    chk("mid_rst_held", {31'd0, held}, 32'd1);
    send_byte(8'h7E, 1'b1);
    tick();
    chk("mid_rst_running", {31'd0, running}, 32'd1);
    fetch("mid_rst_pc0", 8'd0, 8'h7E);
    fetch("mid_rst_pc1", 8'd1, 8'h00);
    fetch("mid_rst_pc255", 8'd255, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
